// File: rtl/dpram_arbiter.sv
// Two-master round-robin arbiter in front of one shared RAM port.
// Commands pass through combinationally. Read responses are routed back to
// the issuing master using an in-order tag FIFO of master IDs.
module dpram_arbiter #(
    parameter int unsigned WIDTHA  = 10,
    parameter int unsigned WIDTHD  = 8,
    parameter int unsigned MAXPEND = 4
) (
    input  logic              clock,
    input  logic              sreset,
    input  logic [WIDTHA-1:0] m0_address,
    input  logic [WIDTHD-1:0] m0_writedata,
    input  logic              m0_read,
    input  logic              m0_write,
    output logic [WIDTHD-1:0] m0_readdata,
    output logic              m0_waitrequest,
    output logic              m0_readdatavalid,
    input  logic [WIDTHA-1:0] m1_address,
    input  logic [WIDTHD-1:0] m1_writedata,
    input  logic              m1_read,
    input  logic              m1_write,
    output logic [WIDTHD-1:0] m1_readdata,
    output logic              m1_waitrequest,
    output logic              m1_readdatavalid,
    output logic [WIDTHA-1:0] s_address,
    output logic [WIDTHD-1:0] s_writedata,
    output logic              s_read,
    output logic              s_write,
    input  logic [WIDTHD-1:0] s_readdata,
    input  logic              s_waitrequest,
    input  logic              s_readdatavalid,
    output logic              err
);

    localparam int unsigned PW = (MAXPEND > 1) ? $clog2(MAXPEND) : 1;
    localparam int unsigned CW = PW + 1;

    logic [MAXPEND-1:0] tag_q;
    logic [PW-1:0]      rd_ptr_q;
    logic [PW-1:0]      wr_ptr_q;
    logic [CW-1:0]      count_q;
    logic               last_grant_q;
    logic               lock_q;
    logic               lock_id_q;
    logic               err_q;

    logic req0, req1;
    logic gnt_valid, gnt_id;
    logic gnt_read, gnt_write;
    logic full, empty, rd_stall, accept, push, pop;

    assign req0 = m0_read | m0_write;
    assign req1 = m1_read | m1_write;

    // Grant selection: held grant first, then round-robin on a tie.
    always_comb begin
        gnt_valid = 1'b0;
        gnt_id    = 1'b0;
        if (!sreset) begin
            if (lock_q && (lock_id_q ? req1 : req0)) begin
                gnt_valid = 1'b1;
                gnt_id    = lock_id_q;
            end else if (req0 && req1) begin
                gnt_valid = 1'b1;
                gnt_id    = ~last_grant_q;
            end else if (req0) begin
                gnt_valid = 1'b1;
                gnt_id    = 1'b0;
            end else if (req1) begin
                gnt_valid = 1'b1;
                gnt_id    = 1'b1;
            end
        end
    end

    // Write beats read when a master raises both strobes.
    assign gnt_write = gnt_valid & (gnt_id ? m1_write : m0_write);
    assign gnt_read  = gnt_valid & ~gnt_write & (gnt_id ? m1_read : m0_read);

    // Full is taken from the registered count, so a same-cycle pop does not free a slot.
    assign full     = (count_q == CW'(MAXPEND));
    assign empty    = (count_q == '0);
    assign rd_stall = gnt_read & full;
    assign accept   = gnt_valid & ~s_waitrequest & ~rd_stall;
    assign push     = accept & gnt_read;
    assign pop      = s_readdatavalid & ~empty & ~sreset;

    assign s_address   = gnt_valid ? (gnt_id ? m1_address : m0_address) : '0;
    assign s_writedata = gnt_valid ? (gnt_id ? m1_writedata : m0_writedata) : '0;
    assign s_read      = gnt_read & ~rd_stall;
    assign s_write     = gnt_write;

    assign m0_waitrequest = sreset ? 1'b1 :
                            (gnt_valid && !gnt_id) ? (s_waitrequest | rd_stall) : req0;
    assign m1_waitrequest = sreset ? 1'b1 :
                            (gnt_valid && gnt_id) ? (s_waitrequest | rd_stall) : req1;

    assign m0_readdata      = s_readdata;
    assign m1_readdata      = s_readdata;
    assign m0_readdatavalid = pop & ~tag_q[rd_ptr_q];
    assign m1_readdatavalid = pop & tag_q[rd_ptr_q];
    assign err              = err_q;

    // Tag FIFO, arbitration history, grant lock and sticky error flag.
    always_ff @(posedge clock) begin
        if (sreset) begin
            tag_q        <= '0;
            rd_ptr_q     <= '0;
            wr_ptr_q     <= '0;
            count_q      <= '0;
            last_grant_q <= 1'b1;
            lock_q       <= 1'b0;
            lock_id_q    <= 1'b0;
            err_q        <= 1'b0;
        end else begin
            if (push) begin
                tag_q[wr_ptr_q] <= gnt_id;
                wr_ptr_q        <= wr_ptr_q + PW'(1);
            end
            if (pop) begin
                rd_ptr_q <= rd_ptr_q + PW'(1);
            end
            if (push && !pop) begin
                count_q <= count_q + CW'(1);
            end else if (pop && !push) begin
                count_q <= count_q - CW'(1);
            end
            if (s_readdatavalid && empty) begin
                err_q <= 1'b1;
            end
            if (accept) begin
                last_grant_q <= gnt_id;
            end
            lock_q    <= gnt_valid & ~accept;
            lock_id_q <= gnt_id;
        end
    end

endmodule

// File: tb/tb_dpram_arbiter.sv
// Randomised and directed bench for dpram_arbiter against a queue-based reference model.
module tb_dpram_arbiter;

    localparam int unsigned WA = 10;
    localparam int unsigned WD = 8;
    localparam int unsigned MP = 4;

    logic          clock = 1'b0;
    logic          sreset;
    logic [WA-1:0] m0_address, m1_address, s_address;
    logic [WD-1:0] m0_writedata, m1_writedata, s_writedata;
    logic          m0_read, m0_write, m1_read, m1_write;
    logic [WD-1:0] m0_readdata, m1_readdata, s_readdata;
    logic          m0_waitrequest, m1_waitrequest;
    logic          m0_readdatavalid, m1_readdatavalid;
    logic          s_read, s_write, s_waitrequest, s_readdatavalid, err;

    int n_checks = 0;
    int n_fail   = 0;

    // reference model state
    int pend[$];
    int last_g;
    int lock_m;
    bit merr;

    // outputs captured in the most recent cycle
    logic [WA-1:0] snap_addr;
    logic snap_sread, snap_swrite, snap_w0, snap_w1, snap_rdv0, snap_rdv1, snap_err;

    dpram_arbiter #(.WIDTHA(WA), .WIDTHD(WD), .MAXPEND(MP)) dut (
        .clock(clock), .sreset(sreset),
        .m0_address(m0_address), .m0_writedata(m0_writedata),
        .m0_read(m0_read), .m0_write(m0_write),
        .m0_readdata(m0_readdata), .m0_waitrequest(m0_waitrequest),
        .m0_readdatavalid(m0_readdatavalid),
        .m1_address(m1_address), .m1_writedata(m1_writedata),
        .m1_read(m1_read), .m1_write(m1_write),
        .m1_readdata(m1_readdata), .m1_waitrequest(m1_waitrequest),
        .m1_readdatavalid(m1_readdatavalid),
        .s_address(s_address), .s_writedata(s_writedata),
        .s_read(s_read), .s_write(s_write),
        .s_readdata(s_readdata), .s_waitrequest(s_waitrequest),
        .s_readdatavalid(s_readdatavalid), .err(err)
    );

    always #5 clock = ~clock;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic model_reset();
        pend.delete();
        last_g = 1;
        lock_m = -1;
        merr   = 1'b0;
    endtask

    task automatic idle();
        m0_read = 0; m0_write = 0; m1_read = 0; m1_write = 0;
        s_waitrequest = 0; s_readdatavalid = 0; sreset = 0;
    endtask

    // One clock cycle: check outputs against the model, then advance the model at the edge.
    task automatic tick();
        bit rq0, rq1, wr_g, rd_g, stall, acc, e_w0, e_w1, e_r0, e_r1;
        int g;
        #1;
        rq0 = m0_read | m0_write;
        rq1 = m1_read | m1_write;
        g = -1;
        if (!sreset) begin
            if (lock_m == 0 && rq0) g = 0;
            else if (lock_m == 1 && rq1) g = 1;
            else if (rq0 && rq1) g = 1 - last_g;
            else if (rq0) g = 0;
            else if (rq1) g = 1;
        end
        wr_g  = (g == 0 && m0_write) || (g == 1 && m1_write);
        rd_g  = !wr_g && ((g == 0 && m0_read) || (g == 1 && m1_read));
        stall = rd_g && (pend.size() == MP);
        acc   = (g >= 0) && !s_waitrequest && !stall;
        e_w0  = sreset ? 1'b1 : (g == 0) ? (s_waitrequest | stall) : rq0;
        e_w1  = sreset ? 1'b1 : (g == 1) ? (s_waitrequest | stall) : rq1;
        e_r0  = !sreset && s_readdatavalid && pend.size() > 0 && pend[0] == 0;
        e_r1  = !sreset && s_readdatavalid && pend.size() > 0 && pend[0] == 1;

        check("s_read", 32'(s_read), 32'(rd_g && !stall));
        check("s_write", 32'(s_write), 32'(wr_g));
        check("m0_wait", 32'(m0_waitrequest), 32'(e_w0));
        check("m1_wait", 32'(m1_waitrequest), 32'(e_w1));
        check("m0_rdv", 32'(m0_readdatavalid), 32'(e_r0));
        check("m1_rdv", 32'(m1_readdatavalid), 32'(e_r1));
        check("err", 32'(err), 32'(merr));
        check("m0_rdata", 32'(m0_readdata), 32'(s_readdata));
        check("m1_rdata", 32'(m1_readdata), 32'(s_readdata));
        if (g >= 0)
            check("s_addr", 32'(s_address), 32'(g == 0 ? m0_address : m1_address));
        if (wr_g)
            check("s_wdata", 32'(s_writedata), 32'(g == 0 ? m0_writedata : m1_writedata));

        snap_addr = s_address; snap_sread = s_read; snap_swrite = s_write;
        snap_w0 = m0_waitrequest; snap_w1 = m1_waitrequest;
        snap_rdv0 = m0_readdatavalid; snap_rdv1 = m1_readdatavalid; snap_err = err;

        @(posedge clock);
        if (sreset) begin
            model_reset();
        end else begin
            if (s_readdatavalid) begin
                if (pend.size() > 0) void'(pend.pop_front());
                else merr = 1'b1;
            end
            if (acc && rd_g) pend.push_back(g);
            if (acc) last_g = g;
            lock_m = (g >= 0 && !acc) ? g : -1;
        end
        @(negedge clock);
    endtask

    initial begin
        idle();
        sreset = 1;
        m0_address = '0; m1_address = '0; m0_writedata = '0; m1_writedata = '0;
        s_readdata = '0;
        repeat (2) @(posedge clock);
        model_reset();
        @(negedge clock);

        // reset state while still in reset, with requests present
        m0_read = 1; m1_write = 1;
        tick();
        check("rst_w0", 32'(snap_w0), 32'd1);
        check("rst_w1", 32'(snap_w1), 32'd1);
        check("rst_sread", 32'(snap_sread), 32'd0);
        check("rst_swrite", 32'(snap_swrite), 32'd0);
        idle();

        // simultaneous reads: m0 first, m1 next, responses routed in order
        m0_read = 1; m0_address = 10'h010; m1_read = 1; m1_address = 10'h020;
        tick();
        check("tie_addr0", 32'(snap_addr), 32'h010);
        check("tie_w1", 32'(snap_w1), 32'd1);
        m0_read = 0;
        tick();
        check("tie_addr1", 32'(snap_addr), 32'h020);
        m1_read = 0;
        s_readdatavalid = 1; s_readdata = 8'hA5;
        tick();
        check("rdv_m0", 32'(snap_rdv0), 32'd1);
        s_readdata = 8'h5A;
        tick();
        check("rdv_m1", 32'(snap_rdv1), 32'd1);
        idle();

        // continuous writes from both masters alternate
        m0_write = 1; m0_address = 10'h100; m0_writedata = 8'h11;
        m1_write = 1; m1_address = 10'h200; m1_writedata = 8'h22;
        for (int i = 0; i < 4; i++) begin
            tick();
            check("alt_addr", 32'(snap_addr), (i % 2 == 0) ? 32'h100 : 32'h200);
            check("alt_sw", 32'(snap_swrite), 32'd1);
        end
        idle();

        // stalled m1 keeps the grant while m0 waits
        m1_write = 1; s_waitrequest = 1;
        tick();
        check("lock_c1", 32'(snap_addr), 32'h200);
        m0_write = 1;
        for (int i = 0; i < 2; i++) begin
            tick();
            check("lock_hold", 32'(snap_addr), 32'h200);
            check("lock_w0", 32'(snap_w0), 32'd1);
        end
        s_waitrequest = 0;
        tick();
        check("lock_acc", 32'(snap_addr), 32'h200);
        m1_write = 0;
        tick();
        check("lock_m0", 32'(snap_addr), 32'h100);
        idle();

        // four outstanding reads fill the FIFO; fifth waits for a response
        m0_read = 1; m0_address = 10'h030;
        for (int i = 0; i < 4; i++) begin
            tick();
            check("fill_sread", 32'(snap_sread), 32'd1);
        end
        tick();
        check("full_sread", 32'(snap_sread), 32'd0);
        check("full_w0", 32'(snap_w0), 32'd1);
        s_readdatavalid = 1;
        tick();
        check("full_pop_sread", 32'(snap_sread), 32'd0);
        s_readdatavalid = 0;
        tick();
        check("after_pop_sread", 32'(snap_sread), 32'd1);
        m0_read = 0; s_readdatavalid = 1;
        repeat (4) tick();
        idle();

        // response with nothing outstanding sets a sticky error
        s_readdatavalid = 1;
        tick();
        check("orphan_rdv0", 32'(snap_rdv0), 32'd0);
        check("orphan_rdv1", 32'(snap_rdv1), 32'd0);
        s_readdatavalid = 0;
        repeat (3) begin
            tick();
            check("err_sticky", 32'(snap_err), 32'd1);
        end
        sreset = 1;
        tick();
        sreset = 0;
        tick();
        check("err_clear", 32'(snap_err), 32'd0);

        // reset with reads pending; next tie goes to m0
        m0_read = 1; m0_address = 10'h040; m1_read = 1; m1_address = 10'h050;
        tick();
        m0_read = 0;
        tick();
        m1_read = 0; m0_write = 1; m1_write = 1; sreset = 1;
        tick();
        check("rst2_w0", 32'(snap_w0), 32'd1);
        check("rst2_sw", 32'(snap_swrite), 32'd0);
        sreset = 0;
        tick();
        check("rst2_tie", 32'(snap_addr), 32'h040);
        idle();
        s_readdatavalid = 1;
        tick();
        check("rst2_norte", 32'(snap_rdv0 | snap_rdv1), 32'd0);
        s_readdatavalid = 0;
        tick();
        check("rst2_err", 32'(snap_err), 32'd1);

        // random traffic against the model
        for (int i = 0; i < 3000; i++) begin
            sreset          = ($urandom_range(0, 99) == 0);
            m0_read         = ($urandom_range(0, 2) == 0);
            m0_write        = ($urandom_range(0, 3) == 0);
            m1_read         = ($urandom_range(0, 2) == 0);
            m1_write        = ($urandom_range(0, 3) == 0);
            m0_address      = WA'($urandom);
            m1_address      = WA'($urandom);
            m0_writedata    = WD'($urandom);
            m1_writedata    = WD'($urandom);
            s_readdata      = WD'($urandom);
            s_waitrequest   = ($urandom_range(0, 3) == 0);
            s_readdatavalid = ($urandom_range(0, 2) == 0);
            tick();
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/dpram_arbiter.md
DPRAM_ARBITER -- requirements
Module: dpram_arbiter

Interface
REQ-001 SHALL have parameter WIDTHA, default 10, meaning address width in bits.
REQ-002 SHALL have parameter WIDTHD, default 8, meaning data width in bits.
REQ-003 SHALL have parameter MAXPEND, default 4 (power of two, >=2), meaning the maximum number of outstanding reads tracked.
REQ-004 SHALL have port clock  input  1  rising-edge clock for all state.
REQ-005 SHALL have port sreset  input  1  synchronous, active-high reset.
REQ-006 SHALL have ports mN_address (N=0,1)  input  WIDTHA  master N word address.
REQ-007 SHALL have ports mN_writedata  input  WIDTHD  master N write data.
REQ-008 SHALL have ports mN_read / mN_write  input  1 each  master N command strobes.
REQ-009 SHALL have ports mN_readdata  output  WIDTHD  read data returned to master N.
REQ-010 SHALL have ports mN_waitrequest  output  1  master N command-stall signal.
REQ-011 SHALL have ports mN_readdatavalid  output  1  qualifies mN_readdata.
REQ-012 SHALL have ports s_address / s_writedata  output  WIDTHA / WIDTHD  to the shared RAM port.
REQ-013 SHALL have ports s_read / s_write  output  1 each  shared-port command strobes.
REQ-014 SHALL have ports s_readdata  input  WIDTHD, s_waitrequest  input  1, s_readdatavalid  input  1.
REQ-015 SHALL have port err  output  1  sticky flag: readdatavalid received with no read outstanding.

Function
REQ-016 SHALL treat master N as requesting when mN_read | mN_write; if both strobes are high, write SHALL win and the read SHALL be ignored.
REQ-017 SHALL grant at most one master per cycle, combinationally (zero-cycle command path), and drive s_address, s_writedata, s_read and s_write from the granted master only.
REQ-018 SHALL drive s_read = s_write = 0 when no master is granted.
REQ-019 SHALL arbitrate round-robin: with one requester, grant it; with both, grant the master not recorded in last_grant.
REQ-020 SHALL lock the grant: if the granted master was stalled last cycle, the same master SHALL keep the grant this cycle regardless of the other request.
REQ-021 SHALL define accept = granted command & !s_waitrequest & !rd_stall, where rd_stall = granted read & pending FIFO full.
REQ-022 SHALL suppress s_read while rd_stall holds.
REQ-023 SHALL update last_grant to the granted master on accept only.
REQ-024 SHALL drive the granted master's waitrequest = s_waitrequest | rd_stall; the non-granted master's waitrequest SHALL be 1 while it requests and 0 while idle.
REQ-025 SHALL push the granted master ID into a MAXPEND-deep FIFO on each accepted read; writes SHALL NOT be tracked.
REQ-026 SHALL pop the FIFO on s_readdatavalid and set mN_readdatavalid = s_readdatavalid & (FIFO head == N), combinationally with no added latency.
REQ-027 SHALL broadcast s_readdata to both m0_readdata and m1_readdata.
REQ-028 SHALL evaluate "full" on the registered count, so full blocks a new read even when a pop occurs in the same cycle.
REQ-029 SHALL, on a simultaneous push and pop when not full, leave the count unchanged and keep FIFO order intact.
REQ-030 SHALL, on s_readdatavalid with the FIFO empty, assert no mN_readdatavalid, not pop, and set err until reset.
REQ-031 SHALL wrap the FIFO pointers modulo MAXPEND.

Reset
REQ-032 SHALL, on clock edge with sreset=1, clear the FIFO (count 0), clear err and the lock, and set last_grant=1 so m0 wins the first tie.
REQ-033 SHALL, while sreset=1, force s_read = s_write = 0, m0/m1_waitrequest = 1 and m0/m1_readdatavalid = 0.
REQ-034 SHALL, on reset mid-operation, discard outstanding read tags; responses arriving afterwards SHALL set err per REQ-030.

Verification
REQ-035 SHALL be tested with this scenario: after reset, m0 and m1 both read in the same cycle (addr 0x010, 0x020), s_waitrequest=0 -> m0 granted first, m1 next cycle; readdatavalid routed m0 then m1.
REQ-036 SHALL be tested with this scenario: both masters write continuously -> grants alternate m0,m1,m0,m1 with exactly one s_write per cycle.
REQ-037 SHALL be tested with this scenario: m1 granted, s_waitrequest=1 for 3 cycles while m0 requests -> m1 stays granted and its command is held; m0 is granted only after m1's accept.
REQ-038 SHALL be tested with this scenario: with MAXPEND=4, 4 m0 reads accepted and no responses -> 5th read stalls (m0_waitrequest=1, s_read=0); one s_readdatavalid -> 5th read accepted the following cycle.
REQ-039 SHALL be tested with this scenario: s_readdatavalid pulsed with no read outstanding -> both mN_readdatavalid=0, err=1 and held until sreset.
REQ-040 SHALL be tested with this scenario: sreset asserted with 2 reads pending -> FIFO count 0, last_grant=1, then a tie grants m0.
